// File: rtl/cdc_bus_tx_pkg.sv
// rtl/cdc_bus_tx_pkg.sv - shared state encoding, defaults and width helper for cdc_bus_tx
package cdc_bus_tx_pkg;

  // FSM encoding; the numeric values are fixed so the state can be observed on a debug bus.
  typedef enum logic [1:0] {
    ST_RESYNC   = 2'd0,
    ST_IDLE     = 2'd1,
    ST_WAIT_ACK = 2'd2
  } state_t;

  // Default synchronizer depth on the returning ack toggle (legal values: 2 or 3).
  localparam int unsigned SYNC_STAGES_DEFAULT = 2;

  // Bits needed to hold every value from 0 up to and including n.
  function automatic int unsigned ctr_width(input int unsigned n);
    if (n < 1) begin
      return 1;
    end
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/cdc_bus_tx_sync_ack_bit.sv
// rtl/cdc_bus_tx_sync_ack_bit.sv - single-bit multi-flop synchronizer for the returning ack toggle
module cdc_bus_tx_sync_ack_bit
  import cdc_bus_tx_pkg::*;
#(
  parameter int unsigned STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  // The whole chain is marked ASYNC_REG so placement keeps the flops adjacent for MTBF.
  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] r_sync;

  // Shift the asynchronous input through the chain; reset clears every stage.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/cdc_bus_tx.sv
// rtl/cdc_bus_tx.sv - source side of a toggle req/ack bus crossing; optional CDC_BUS_TX_TIMEOUT_EN adds a sticky ack timeout
module cdc_bus_tx
  import cdc_bus_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned SYNC_STAGES    = SYNC_STAGES_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] cdc_data,
  output logic                  cdc_req,
  input  logic                  cdc_ack,
  output logic                  busy,
  output logic                  timeout
);

  // RESYNC waits SYNC_STAGES+1 edges so the ack chain has settled before req is aligned.
  localparam int unsigned        RS_W    = ctr_width(SYNC_STAGES);
  localparam logic [RS_W-1:0]    RS_LAST = RS_W'(SYNC_STAGES);

  state_t                r_state;
  state_t                w_state_nx;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] w_data_nx;
  logic                  r_req;
  logic                  w_req_nx;
  logic                  r_ready;
  logic                  w_ready_nx;
  logic                  r_busy;
  logic                  w_busy_nx;
  logic [RS_W-1:0]       r_rs_cnt;
  logic [RS_W-1:0]       w_rs_cnt_nx;
  logic                  w_ack_sync;
  logic                  w_accept;

  cdc_bus_tx_sync_ack_bit #(
    .STAGES (SYNC_STAGES)
  ) u_sync_ack (
    .i_clk (clk_in),
    .i_rst (reset),
    .i_d   (cdc_ack),
    .o_q   (w_ack_sync)
  );

  // A word is taken only in IDLE with ready already high, so accepts can never be back-to-back.
  assign w_accept = (r_state == ST_IDLE) && r_ready && in_valid;

  // State and registered outputs; reset discards any transfer in flight.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_state  <= ST_RESYNC;
      r_data   <= '0;
      r_req    <= 1'b0;
      r_ready  <= 1'b0;
      r_busy   <= 1'b1;
      r_rs_cnt <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_data   <= w_data_nx;
      r_req    <= w_req_nx;
      r_ready  <= w_ready_nx;
      r_busy   <= w_busy_nx;
      r_rs_cnt <= w_rs_cnt_nx;
    end
  end

  // Next-state and next-output decode; everything holds unless a case below changes it.
  always_comb begin
    w_state_nx  = r_state;
    w_data_nx   = r_data;
    w_req_nx    = r_req;
    w_ready_nx  = r_ready;
    w_busy_nx   = r_busy;
    w_rs_cnt_nx = r_rs_cnt;
    case (r_state)
      ST_RESYNC: begin
        w_ready_nx = 1'b0;
        w_busy_nx  = 1'b1;
        if (r_rs_cnt == RS_LAST) begin
          // Adopt the receiver's ack level as our req level so no edge is announced.
          w_req_nx    = w_ack_sync;
          w_ready_nx  = 1'b1;
          w_busy_nx   = 1'b0;
          w_rs_cnt_nx = '0;
          w_state_nx  = ST_IDLE;
        end else begin
          w_rs_cnt_nx = r_rs_cnt + RS_W'(1);
        end
      end
      ST_IDLE: begin
        // A spurious ack toggle here is deliberately ignored.
        if (w_accept) begin
          // Data and req move together; the receiver only samples data after synchronizing req.
          w_data_nx  = in_data;
          w_req_nx   = ~r_req;
          w_ready_nx = 1'b0;
          w_busy_nx  = 1'b1;
          w_state_nx = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        // in_valid is ignored here; the data register stays frozen until the ack matches.
        if (w_ack_sync == r_req) begin
          w_ready_nx = 1'b1;
          w_busy_nx  = 1'b0;
          w_state_nx = ST_IDLE;
        end
      end
      default: begin
        w_state_nx  = ST_RESYNC;
        w_ready_nx  = 1'b0;
        w_busy_nx   = 1'b1;
        w_rs_cnt_nx = '0;
      end
    endcase
  end

`ifdef CDC_BUS_TX_TIMEOUT_EN
  localparam int unsigned     TO_W    = ctr_width(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_timeout;

  // Count WAIT_ACK cycles (saturating) and latch the sticky flag on the TIMEOUT_CYCLES-th one.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_accept) begin
        r_to_cnt <= '0;
      end else if (r_state == ST_WAIT_ACK && r_to_cnt != TO_MAX) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end
      if (r_state == ST_WAIT_ACK && r_to_cnt == TO_LAST) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign timeout = r_timeout;
`else
  // Without the watchdog the limit parameter has no consumer.
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYCLES == 0);
  assign timeout      = 1'b0;
`endif

  assign in_ready = r_ready;
  assign cdc_data = r_data;
  assign cdc_req  = r_req;
  assign busy     = r_busy;

endmodule

// File: tb/tb_cdc_bus_tx.sv
// tb/tb_cdc_bus_tx.sv - directed scoreboard bench for cdc_bus_tx
module tb_cdc_bus_tx;

  localparam int DW  = 32;
  localparam int SS  = 2;
  localparam int TOC = 16;
`ifdef CDC_BUS_TX_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk_in   = 1'b0;
  logic          reset    = 1'b1;
  logic [DW-1:0] in_data  = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] cdc_data;
  logic          cdc_req;
  logic          cdc_ack;
  logic          busy;
  logic          timeout;

  int            tests    = 0;
  int            fails    = 0;
  logic [DW-1:0] sb[$];
  logic [DW-1:0] exp_word = '0;
  logic          exp_req  = 1'b0;
  int            toggles  = 0;
  int            tog0     = 0;
  bit            mon_en   = 1'b0;
  logic          prev_req = 1'b0;

  logic          ack_man   = 1'b0;
  logic          ack_auto  = 1'b0;
  bit            auto_mode = 1'b0;
  int            dly       = 0;

  assign cdc_ack = auto_mode ? ack_auto : ack_man;

  cdc_bus_tx #(
    .DATA_WIDTH     (DW),
    .SYNC_STAGES    (SS),
    .TIMEOUT_CYCLES (TOC)
  ) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .cdc_data (cdc_data),
    .cdc_req  (cdc_req),
    .cdc_ack  (cdc_ack),
    .busy     (busy),
    .timeout  (timeout)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clk_in);
      n++;
    end
    chk(tag, 64'(in_ready), 64'(1));
  endtask

  // Receiver model: echoes req onto ack a few cycles after each new req edge.
  always @(negedge clk_in) begin
    if (!auto_mode) begin
      ack_auto = ack_man;
      dly      = 0;
    end else if (cdc_req !== ack_auto) begin
      if (dly == 3) begin
        ack_auto = cdc_req;
        dly      = 0;
      end else begin
        dly++;
      end
    end else begin
      dly = 0;
    end
  end

  // Scoreboard monitor: every req edge must carry the oldest pushed word, held while busy.
  always @(negedge clk_in) begin
    if (mon_en) begin
      if (cdc_req !== prev_req) begin
        toggles++;
        chk("sb_nonempty_on_req", 64'(sb.size() != 0), 64'(1));
        if (sb.size() != 0) begin
          exp_word = sb.pop_front();
          chk("cdc_data_on_req", 64'(cdc_data), 64'(exp_word));
        end
      end
      if (busy === 1'b1) begin
        chk("cdc_data_hold_busy", 64'(cdc_data), 64'(exp_word));
      end
    end
    prev_req = cdc_req;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk_in);
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_busy",     64'(busy),     64'(1));
    chk("rst_req",      64'(cdc_req),  64'(0));
    chk("rst_data",     64'(cdc_data), 64'(0));
    chk("rst_timeout",  64'(timeout),  64'(0));
    reset = 1'b0;
    repeat (SS) begin
      @(negedge clk_in);
      chk("resync_ready_low", 64'(in_ready), 64'(0));
    end
    @(negedge clk_in);
    chk("resync_ready_high", 64'(in_ready), 64'(1));
    chk("resync_busy",       64'(busy),     64'(0));
    chk("resync_req",        64'(cdc_req),  64'(0));
    mon_en = 1'b1;

    // Single transfer with a manual ack five cycles later
    in_data  = 32'hDEADBEEF;
    in_valid = 1'b1;
    sb.push_back(32'hDEADBEEF);
    @(negedge clk_in);
    in_valid = 1'b0;
    exp_req  = ~exp_req;
    chk("single_data",  64'(cdc_data), 64'(32'hDEADBEEF));
    chk("single_req",   64'(cdc_req),  64'(exp_req));
    chk("single_ready", 64'(in_ready), 64'(0));
    chk("single_busy",  64'(busy),     64'(1));
    repeat (4) begin
      @(negedge clk_in);
      chk("single_wait_ready", 64'(in_ready), 64'(0));
    end
    ack_man = 1'b1;
    repeat (SS) begin
      @(negedge clk_in);
      chk("single_ack_latency_low", 64'(in_ready), 64'(0));
    end
    @(negedge clk_in);
    chk("single_ack_latency_high", 64'(in_ready), 64'(1));
    chk("single_idle_busy",        64'(busy),     64'(0));

    // Back-to-back with in_valid held high and an automatic receiver
    auto_mode = 1'b1;
    tog0      = toggles;
    in_valid  = 1'b1;
    for (int w = 1; w <= 3; w++) begin
      in_data = DW'(w);
      sb.push_back(DW'(w));
      wait_ready("b2b_ready");
      @(negedge clk_in);
      exp_req = ~exp_req;
      chk("b2b_req", 64'(cdc_req), 64'(exp_req));
    end
    in_valid = 1'b0;
    wait_ready("b2b_drain");
    chk("b2b_toggles", 64'(toggles - tog0), 64'(3));
    chk("b2b_sb_empty", 64'(sb.size()), 64'(0));

    // Reset mid-transfer with ack high during and after reset
    auto_mode = 1'b0;
    ack_man   = ack_auto;
    in_data   = 32'h55;
    in_valid  = 1'b1;
    sb.push_back(32'h55);
    @(negedge clk_in);
    in_valid = 1'b0;
    exp_req  = ~exp_req;
    chk("mid_accept_req", 64'(cdc_req), 64'(exp_req));
    @(negedge clk_in);
    mon_en  = 1'b0;
    ack_man = 1'b1;
    reset   = 1'b1;
    #1;
    chk("mid_rst_data",    64'(cdc_data), 64'(0));
    chk("mid_rst_req",     64'(cdc_req),  64'(0));
    chk("mid_rst_ready",   64'(in_ready), 64'(0));
    chk("mid_rst_busy",    64'(busy),     64'(1));
    chk("mid_rst_timeout", 64'(timeout),  64'(0));
    repeat (2) @(negedge clk_in);
    reset = 1'b0;
    repeat (SS) begin
      @(negedge clk_in);
      chk("mid_resync_ready_low", 64'(in_ready), 64'(0));
      chk("mid_resync_req_low",   64'(cdc_req),  64'(0));
    end
    @(negedge clk_in);
    chk("mid_resync_ready", 64'(in_ready), 64'(1));
    chk("mid_resync_req",   64'(cdc_req),  64'(1));
    chk("mid_resync_busy",  64'(busy),     64'(0));
    exp_req  = 1'b1;
    exp_word = '0;
    repeat (4) begin
      @(negedge clk_in);
      chk("mid_no_extra_toggle", 64'(cdc_req), 64'(1));
    end
    mon_en = 1'b1;

    // Spurious ack toggles while idle change nothing
    ack_man = 1'b0;
    repeat (SS + 3) begin
      @(negedge clk_in);
      chk("spur1_ready", 64'(in_ready), 64'(1));
      chk("spur1_req",   64'(cdc_req),  64'(1));
      chk("spur1_busy",  64'(busy),     64'(0));
    end
    ack_man = 1'b1;
    repeat (SS + 3) begin
      @(negedge clk_in);
      chk("spur2_ready", 64'(in_ready), 64'(1));
      chk("spur2_req",   64'(cdc_req),  64'(1));
    end
    in_data  = 32'hA5A5A5A5;
    in_valid = 1'b1;
    sb.push_back(32'hA5A5A5A5);
    @(negedge clk_in);
    in_valid = 1'b0;
    exp_req  = ~exp_req;
    chk("spur_accept_req", 64'(cdc_req), 64'(exp_req));
    repeat (8) begin
      @(negedge clk_in);
      chk("spur_wait_ready", 64'(in_ready), 64'(0));
      chk("spur_wait_busy",  64'(busy),     64'(1));
    end
    ack_man = 1'b0;
    repeat (SS) begin
      @(negedge clk_in);
      chk("spur_match_low", 64'(in_ready), 64'(0));
    end
    @(negedge clk_in);
    chk("spur_match_high", 64'(in_ready), 64'(1));

    // Long wait without ack: in_valid ignored, timeout after TOC cycles when enabled
    in_data  = 32'h00000077;
    in_valid = 1'b1;
    sb.push_back(32'h00000077);
    @(negedge clk_in);
    exp_req = ~exp_req;
    chk("to_accept_req", 64'(cdc_req), 64'(exp_req));
    in_data = 32'h12345678;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk_in);
      chk("to_flag",       64'(timeout),  64'(TO_EN && (j >= TOC)));
      chk("to_wait_ready", 64'(in_ready), 64'(0));
    end
    in_valid = 1'b0;
    ack_man  = 1'b1;
    repeat (SS) begin
      @(negedge clk_in);
      chk("to_late_ack_low", 64'(in_ready), 64'(0));
    end
    @(negedge clk_in);
    chk("to_late_ack_ready", 64'(in_ready), 64'(1));
    chk("to_late_ack_busy",  64'(busy),     64'(0));
    repeat (3) begin
      @(negedge clk_in);
      chk("to_sticky", 64'(timeout), 64'(TO_EN));
    end
    chk("final_sb_empty", 64'(sb.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cdc_bus_tx.md
Name: cdc_bus_tx

Overview:
Source-domain transmitter of a 2-phase (toggle) req/ack handshake that moves a multi-bit bus across a clock-domain boundary as one coherent word.
- Accepts words through a valid/ready interface.
- Holds each word stable on cdc_data and toggles cdc_req to announce it.
- Synchronizes the returning cdc_ack toggle internally before reusing the data register.
- Sits in the sending clock domain; the matching receiver in the destination domain returns cdc_ack.

Parameters:
- DATA_WIDTH, 32: width of the transferred word.
- SYNC_STAGES, 2: synchronizer depth on cdc_ack; legal values 2 or 3.
- TIMEOUT_CYCLES, 1024: WAIT_ACK cycles before timeout is flagged; used only with the optional feature.

Ports:
- clk_in  input  1  source-domain clock; all logic is on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  DATA_WIDTH  word to transfer.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word.
- cdc_data  output  DATA_WIDTH  registered word; stable from the cdc_req toggle until the ack is seen.
- cdc_req  output  1  registered request toggle; each edge announces a new word.
- cdc_ack  input  1  acknowledge toggle from the destination domain; asynchronous to clk_in.
- busy  output  1  high while a transfer is outstanding (state != IDLE).
- timeout  output  1  sticky timeout flag; tied 0 without the optional feature.

Behaviour:
- Synchronizer: ack_sync is the last stage of a SYNC_STAGES chain of ASYNC_REG flops fed by cdc_ack. The chain resets to 0.
- Reset values: cdc_data=0, cdc_req=0, in_ready=0, busy=1, timeout=0, state=RESYNC, sync chain=0.
- FSM state RESYNC:
  - Counts SYNC_STAGES+1 cycles after reset release.
  - Then loads cdc_req <= ack_sync, so no edge is generated.
  - Then moves to IDLE with in_ready=1 and busy=0.
  - Any transfer in flight when reset asserted is discarded; whether the receiver delivered it is undefined.
- FSM state IDLE:
  - in_ready=1.
  - On in_valid & in_ready at edge k: cdc_data <= in_data; cdc_req <= ~cdc_req; in_ready <= 0; busy <= 1; state <= WAIT_ACK. All of these update on edge k.
  - cdc_data and cdc_req change on the same edge. This is legal because the receiver samples data only after synchronizing req.
- FSM state WAIT_ACK:
  - in_ready=0. in_valid is ignored; upstream holds the word per valid/ready rules.
  - When ack_sync == cdc_req: state <= IDLE, in_ready <= 1, busy <= 0.
  - Latency: if cdc_ack toggles between edges a and a+1, in_ready rises at edge a+SYNC_STAGES+1.
- Minimum transfer period: 1 (accept) + receiver round trip + SYNC_STAGES + 1 clk_in cycles. Back-to-back accepts are impossible by construction.
- Spurious cdc_ack toggle in IDLE: no state change. The word accepted next waits for a matching ack.
- Reset asserted mid-transfer: all outputs take reset values immediately (asynchronous); then the RESYNC sequence applies.
- cdc_data never changes while busy=1.

Optional Feature:
- Macro: CDC_BUS_TX_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) clears on entry to WAIT_ACK and increments each WAIT_ACK cycle.
  - When it reaches TIMEOUT_CYCLES, timeout <= 1.
  - timeout is sticky until reset. The FSM keeps waiting and the protocol is not broken.
- Undefined: no counter; timeout is constant 0.

Decomposition:
- Shared package/include:
  - 2-bit state encoding constants: RESYNC=0, IDLE=1, WAIT_ACK=2.
  - SYNC_STAGES default.
  - Counter-width helper function.
- One natural sub-module: sync_ack_bit.
  - Single-bit, SYNC_STAGES-deep ASYNC_REG synchronizer with asynchronous active-high reset to 0.
  - Instantiated once for cdc_ack.

Test Plan:
- Reset release, cdc_ack=0: in_ready=0 for SYNC_STAGES+1 cycles, then 1; cdc_req=0, busy=0.
- Single transfer: in_data=0xDEADBEEF, in_valid=1 for one accepted cycle.
  - cdc_data=0xDEADBEEF and cdc_req=1 on the same edge.
  - Bench toggles cdc_ack 5 cycles later; in_ready returns exactly SYNC_STAGES+1 edges after the toggle.
- Back-to-back: in_valid held high with 0x1, 0x2, 0x3.
  - Exactly three cdc_req toggles and three accepts.
  - cdc_data is never changed while busy=1.
- Reset mid-transfer after accept of 0x55, with bench cdc_ack=1 during and after reset:
  - Outputs go to reset values immediately.
  - After RESYNC, cdc_req=1 (aligned) and in_ready=1 with no extra toggle.
- Spurious cdc_ack toggle in IDLE: no output change. The next accept waits for a second matching toggle.
- With CDC_BUS_TX_TIMEOUT_EN and TIMEOUT_CYCLES=16, no ack returned:
  - timeout=1 after 16 WAIT_ACK cycles and stays 1.
  - A late ack still returns the FSM to IDLE.
